// File: rtl/conv_pe_sequencer_pkg.sv
// Shared constants, FSM encoding and tap addressing for the 4x4 * 3x3 convolution sequencer.
package conv_pe_sequencer_pkg;

    localparam int DATA_W     = 8;
    localparam int N_IN       = 16;
    localparam int N_TAPS     = 9;
    localparam int N_WIN      = 4;
    localparam int WIN_CYCLES = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_STORE,
        ST_DONE
    } state_t;

    // Row-major index of the input pixel read by tap k of window win.
    function automatic logic [3:0] in_index(input logic [1:0] win, input logic [3:0] tap);
        int ky;
        int kx;
        ky = int'(tap) / 3;
        kx = int'(tap) % 3;
        return 4'((int'(win[1]) + ky) * 4 + int'(win[0]) + kx);
    endfunction

endpackage

// File: rtl/conv_pe_sequencer_if.sv
// Control, operand and result bundle between the sequencer and its host.
interface conv_pe_sequencer_if;
    import conv_pe_sequencer_pkg::*;

    logic                       start;
    logic [N_IN*DATA_W-1:0]     in_flat;
    logic [N_TAPS*DATA_W-1:0]   fil_flat;
    logic                       busy;
    logic                       done;
    logic                       result_valid;
    logic [DATA_W-1:0]          c11;
    logic [DATA_W-1:0]          c12;
    logic [DATA_W-1:0]          c21;
    logic [DATA_W-1:0]          c22;
    logic [1:0]                 win_idx;
    logic [3:0]                 tap_idx;

    modport master (
        output start, in_flat, fil_flat,
        input  busy, done, result_valid, c11, c12, c21, c22, win_idx, tap_idx
    );

    modport slave (
        input  start, in_flat, fil_flat,
        output busy, done, result_valid, c11, c12, c21, c22, win_idx, tap_idx
    );

endinterface

// File: rtl/conv_pe_sequencer_pe_mac.sv
// Single multiply-accumulate element; product and sum wrap modulo 2^W.
module pe_mac
    import conv_pe_sequencer_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] acc
);

    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] prod;

    assign prod = a * b;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prod;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/conv_pe_sequencer.sv
// Walks four 3x3 windows over a latched 4x4 tile, feeding one shared MAC per tap
// and storing each window sum into its output register.
module conv_pe_sequencer
    import conv_pe_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    conv_pe_sequencer_if.slave bus
);

    state_t                       state_q, state_d;
    logic [3:0]                   tap_q, tap_d;
    logic [1:0]                   win_q, win_d;
    logic [N_IN*DATA_W-1:0]       in_q, in_d;
    logic [N_TAPS*DATA_W-1:0]     fil_q, fil_d;
    logic [N_WIN-1:0][DATA_W-1:0] c_q, c_d;
    logic                         rv_q, rv_d;

    logic                         pe_en;
    logic                         pe_clr;
    logic [DATA_W-1:0]            pe_a;
    logic [DATA_W-1:0]            pe_b;
    logic [DATA_W-1:0]            pe_acc;

    logic [DATA_W-1:0]            in_pix  [N_IN];
    logic [DATA_W-1:0]            fil_pix [N_TAPS];

    // Flat buses are MSB-first, so element 0 sits at the top of the vector.
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_in_pix
        assign in_pix[gi] = in_q[(N_IN-1-gi)*DATA_W +: DATA_W];
    end

    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_fil_pix
        assign fil_pix[gi] = fil_q[(N_TAPS-1-gi)*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_FEED;
            ST_FEED:  if (tap_q == 4'(N_TAPS-1)) state_d = ST_STORE;
            ST_STORE: state_d = (win_q == 2'(N_WIN-1)) ? ST_DONE : ST_CLEAR;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Filter is flipped for a true convolution: tap k pairs with filter element 8-k.
    always_comb begin
        pe_en  = (state_q == ST_FEED);
        pe_clr = (state_q == ST_CLEAR);
        pe_a   = '0;
        pe_b   = '0;
        if (pe_en) begin
            pe_a = in_pix[in_index(win_q, tap_q)];
            pe_b = fil_pix[4'(N_TAPS-1) - tap_q];
        end
    end

    always_comb begin
        tap_d = tap_q;
        win_d = win_q;
        in_d  = in_q;
        fil_d = fil_q;
        c_d   = c_q;
        rv_d  = rv_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    in_d  = bus.in_flat;
                    fil_d = bus.fil_flat;
                    rv_d  = 1'b0;
                    win_d = '0;
                    tap_d = '0;
                end
            end
            ST_CLEAR: tap_d = '0;
            ST_FEED:  tap_d = tap_q + 4'd1;
            ST_STORE: begin
                c_d[win_q] = pe_acc;
                tap_d      = '0;
                if (win_q != 2'(N_WIN-1)) begin
                    win_d = win_q + 2'd1;
                end
            end
            ST_DONE:  rv_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_q <= '0;
            win_q <= '0;
            in_q  <= '0;
            fil_q <= '0;
            c_q   <= '0;
            rv_q  <= 1'b0;
        end else begin
            tap_q <= tap_d;
            win_q <= win_d;
            in_q  <= in_d;
            fil_q <= fil_d;
            c_q   <= c_d;
            rv_q  <= rv_d;
        end
    end

    pe_mac #(.W(DATA_W)) u_pe_mac (
        .clk (clk),
        .rst (rst),
        .clr (pe_clr),
        .en  (pe_en),
        .a   (pe_a),
        .b   (pe_b),
        .acc (pe_acc)
    );

    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = (state_q == ST_DONE);
    assign bus.result_valid = rv_q;
    assign bus.c11          = c_q[0];
    assign bus.c12          = c_q[1];
    assign bus.c21          = c_q[2];
    assign bus.c22          = c_q[3];
    assign bus.win_idx      = win_q;
    assign bus.tap_idx      = (state_q == ST_FEED) ? tap_q : 4'd0;

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Scoreboard bench: accepted starts push a reference convolution result,
// and a monitor pops and compares whenever done is presented.
module tb_conv_pe_sequencer;
    import conv_pe_sequencer_pkg::*;

    localparam int W        = DATA_W;
    localparam int RUN_LEN  = N_WIN * WIN_CYCLES + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_pe_sequencer_if bus();

    conv_pe_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [3:0][W-1:0] c;
        int                acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   cnt       = 0;
    logic rv_exp    = 1'b0;
    int   done_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Direct arithmetic definition: c[oy][ox] = sum in[oy+ky][ox+kx] * fil[2-ky][2-kx] mod 2^W.
    function automatic logic [3:0][W-1:0] conv_ref(input logic [N_IN*W-1:0] inf,
                                                   input logic [N_TAPS*W-1:0] ff);
        int ip [4][4];
        int fp [3][3];
        logic [3:0][W-1:0] r;
        for (int i = 0; i < 16; i++) ip[i/4][i%4] = int'(inf[(15-i)*W +: W]);
        for (int i = 0; i < 9; i++)  fp[i/3][i%3] = int'(ff[(8-i)*W +: W]);
        for (int w = 0; w < 4; w++) begin
            int s = 0;
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++)
                    s += ip[w/2 + ky][w%2 + kx] * fp[2-ky][2-kx];
            r[w] = W'(s);
        end
        return r;
    endfunction

    // Stimulus side of the scoreboard: sees what the DUT sees at each edge.
    always @(posedge clk) begin : acceptor
        exp_t e;
        cyc++;
        if (rst) begin
            cnt    = 0;
            rv_exp = 1'b0;
            exp_q.delete();
        end else if (cnt == 0) begin
            if (bus.start) begin
                e.c       = conv_ref(bus.in_flat, bus.fil_flat);
                e.acc_cyc = cyc;
                exp_q.push_back(e);
                cnt    = RUN_LEN;
                rv_exp = 1'b0;
            end
        end else begin
            cnt--;
            if (cnt == 0) rv_exp = 1'b1;
        end
    end

    initial begin : monitor
        exp_t e;
        int   j;
        int   exp_tap;
        int   exp_win;
        forever begin
            @(posedge clk);
            #1;
            chk("busy", bus.busy, cnt > 0);
            chk("done", bus.done, cnt == 1);
            chk("result_valid", bus.result_valid, rv_exp);
            exp_tap = 0;
            exp_win = 3;
            if (cnt > 1) begin
                j       = RUN_LEN - cnt;
                exp_win = j / WIN_CYCLES;
                if (j % WIN_CYCLES >= 1 && j % WIN_CYCLES <= N_TAPS) exp_tap = j % WIN_CYCLES - 1;
            end
            chk("tap_idx", bus.tap_idx, exp_tap);
            if (cnt > 0) chk("win_idx", bus.win_idx, exp_win);
            if (bus.done) begin
                done_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("c11", bus.c11, e.c[0]);
                    chk("c12", bus.c12, e.c[1]);
                    chk("c21", bus.c21, e.c[2]);
                    chk("c22", bus.c22, e.c[3]);
                    chk("done_latency", cyc - e.acc_cyc, RUN_LEN - 1);
                    $display("run done: c=%0d,%0d,%0d,%0d latency=%0d", bus.c11, bus.c12,
                             bus.c21, bus.c22, cyc - e.acc_cyc);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (cnt == 0) return;
        end
        checks++;
        failures++;
        $display("FAIL idle_timeout actual=busy required=idle (t=%0t)", $time);
    endtask

    task automatic run(input logic [N_IN*W-1:0] inf, input logic [N_TAPS*W-1:0] ff,
                       input bit toggle);
        logic [127:0] r128;
        logic [95:0]  r96;
        wait_idle();
        bus.in_flat  = inf;
        bus.fil_flat = ff;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (toggle && cnt > 0) begin
            r128 = {$urandom, $urandom, $urandom, $urandom};
            r96  = {$urandom, $urandom, $urandom};
            bus.start    = 1'($urandom_range(0, 1));
            bus.in_flat  = r128;
            bus.fil_flat = r96[N_TAPS*W-1:0];
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_idle();
    endtask

    task automatic check_c(input string tag, input int a, input int b, input int c, input int d);
        chk({tag, "_c11"}, bus.c11, a);
        chk({tag, "_c12"}, bus.c12, b);
        chk({tag, "_c21"}, bus.c21, c);
        chk({tag, "_c22"}, bus.c22, d);
    endtask

    task automatic check_all_zero();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rv", bus.result_valid, 0);
        chk("rst_win", bus.win_idx, 0);
        chk("rst_tap", bus.tap_idx, 0);
        check_c("rst", 0, 0, 0, 0);
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [N_IN*W-1:0]   ramp;
        logic [N_TAPS*W-1:0] f22;
        logic [N_TAPS*W-1:0] f11;
        logic [127:0]        r128;
        logic [95:0]         r96;
        int                  d0;

        bus.start    = 1'b0;
        bus.in_flat  = '0;
        bus.fil_flat = '0;
        for (int i = 0; i < 16; i++) ramp[(15-i)*W +: W] = W'(i + 1);
        f22 = '0;
        f22[4*W +: W] = W'(1);
        f11 = '0;
        f11[8*W +: W] = W'(1);

        repeat (3) @(negedge clk);
        check_all_zero();
        rst = 1'b0;

        run({16{8'd1}}, {9{8'd1}}, 1'b0);
        check_c("ones", 9, 9, 9, 9);
        chk("ones_rv", bus.result_valid, 1);
        run(ramp, f22, 1'b0);
        check_c("center", 6, 7, 10, 11);
        run(ramp, f11, 1'b1);
        check_c("flip", 11, 12, 15, 16);
        run({16{8'd10}}, {9{8'd3}}, 1'b0);
        check_c("wrap14", 14, 14, 14, 14);
        run({16{8'd16}}, {9{8'd16}}, 1'b1);
        check_c("wrap0", 0, 0, 0, 0);

        // Start held high: back-to-back runs separated by one IDLE cycle.
        wait_idle();
        d0           = done_seen;
        bus.in_flat  = ramp;
        bus.fil_flat = {9{8'd2}};
        bus.start    = 1'b1;
        repeat (100) @(negedge clk);
        bus.start = 1'b0;
        chk("held_start_dones", done_seen - d0, 2);
        wait_idle();

        // Abort mid-run; nothing from the aborted run may survive.
        bus.in_flat  = {16{8'd7}};
        bus.fil_flat = {9{8'd5}};
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run({16{8'd1}}, {9{8'd1}}, 1'b0);
        check_c("after_rst", 9, 9, 9, 9);

        for (int t = 0; t < 16; t++) begin
            r128 = {$urandom, $urandom, $urandom, $urandom};
            r96  = {$urandom, $urandom, $urandom};
            run(r128, r96[N_TAPS*W-1:0], 1'(t % 2));
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
